// File: rtl/step_pkg.sv
// Shared types and constants for the step conditioner.
// Holds the button FSM state enum, counter width and synchronizer depth.
package step_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } btn_state_e;

  localparam int STEP_CNT_W = 8;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/step_conditioner_debounce_cell.sv
// debounce_cell: 2-flop synchronizer plus stable-count debouncer, one bit.
// Ports: clk, i_rst_n, i_raw (async), i_hold (postpone update), o_deb, o_upd.
module debounce_cell
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_hold,
  output logic o_deb,
  output logic o_upd
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic [CW-1:0]         r_cnt;
  logic                  r_deb;
  logic                  w_sync;
  logic                  w_diff;
  logic                  w_full;

  assign w_sync = r_sync[SYNC_DEPTH-1];
  assign w_diff = w_sync ^ r_deb;
  assign w_full = (r_cnt == LAST);
  // Update fires on the edge the stable count reaches DEBOUNCE_CYCLES.
  assign o_upd  = w_diff & w_full & ~i_hold;
  assign o_deb  = r_deb;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_raw};
    end
  end

  // While held, the count parks at LAST so the update lands next cycle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (o_upd) begin
      r_cnt <= '0;
      r_deb <= w_sync;
    end else if (!w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_conditioner.sv
// step_conditioner: debounced switches plus single-step pulse generator.
// Ports: clk, reset (async low), sw_raw, btn_raw -> sw_out, step_pulse,
// step_count. Macro STEP_AUTOREPEAT_EN adds the REPEAT state and timer.
module step_conditioner
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sw_raw,
  input  logic                  btn_raw,
  output logic [1:0]            sw_out,
  output logic                  step_pulse,
  output logic [STEP_CNT_W-1:0] step_count
);

  btn_state_e            r_state;
  btn_state_e            w_state_nxt;
  logic                  w_pulse_nxt;
  logic                  r_pulse;
  logic [STEP_CNT_W-1:0] r_count;
  logic [1:0]            w_sw_upd;
  logic                  w_btn_deb;
  logic                  w_btn_upd;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_unused;

  // Switch updates are held off in the cycle a pulse is about to issue.
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
    .clk     (clk),
    .i_rst_n (reset),
    .i_raw   (sw_raw[0]),
    .i_hold  (w_pulse_nxt),
    .o_deb   (sw_out[0]),
    .o_upd   (w_sw_upd[0])
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .clk     (clk),
    .i_rst_n (reset),
    .i_raw   (sw_raw[1]),
    .i_hold  (w_pulse_nxt),
    .o_deb   (sw_out[1]),
    .o_upd   (w_sw_upd[1])
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .i_rst_n (reset),
    .i_raw   (btn_raw),
    .i_hold  (1'b0),
    .o_deb   (w_btn_deb),
    .o_upd   (w_btn_upd)
  );

  assign w_unused = &{1'b0, w_sw_upd};

  // Strobes coincide with the debounced register edge, so the pulse
  // rises on the same edge as the debounced button.
  assign w_rise = w_btn_upd & ~w_btn_deb;
  assign w_fall = w_btn_upd & w_btn_deb;

`ifdef STEP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] r_rep;
  logic          w_rep_hit;

  assign w_rep_hit = (r_rep == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep <= '0;
    end else if (r_state == RELEASED || w_fall || w_pulse_nxt) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`else
  if (REPEAT_CYCLES < 2) begin : g_rep_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RELEASED: if (w_rise) w_state_nxt = PRESSED;
`ifdef STEP_AUTOREPEAT_EN
      PRESSED: begin
        if (w_fall)         w_state_nxt = RELEASED;
        else if (w_rep_hit) w_state_nxt = REPEAT;
      end
      REPEAT:   if (w_fall) w_state_nxt = RELEASED;
`else
      PRESSED:  if (w_fall) w_state_nxt = RELEASED;
`endif
      default:  w_state_nxt = RELEASED;
    endcase
  end

  always_comb begin
    w_pulse_nxt = (r_state == RELEASED) && w_rise;
`ifdef STEP_AUTOREPEAT_EN
    if ((r_state == PRESSED || r_state == REPEAT) && !w_fall && w_rep_hit)
      w_pulse_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pulse <= 1'b0;
      r_count <= '0;
    end else begin
      r_pulse <= w_pulse_nxt;
      r_count <= r_count + STEP_CNT_W'(w_pulse_nxt);
    end
  end

  assign step_pulse = r_pulse;
  assign step_count = r_count;

endmodule

// File: tb/tb_step_conditioner.sv
// Scoreboard bench for step_conditioner with DEBOUNCE_CYCLES=4.
// Expected switch and pulse events are queued when stimulus is driven.
module tb_step_conditioner;
  import step_pkg::*;

  localparam int D  = 4;
  localparam int RP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic       btn_raw = 1'b0;
  logic [1:0] sw_out;
  logic       step_pulse;
  logic [7:0] step_count;

  step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .sw_out     (sw_out),
    .step_pulse (step_pulse),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         e;
    logic [7:0] v;
  } ev_t;

  ev_t        q_sw[$];
  ev_t        q_pl[$];
  ev_t        ev;
  logic [1:0] prev_sw = 2'b00;
  logic [7:0] m_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_sw = 2'b00;
    end else begin
      if (sw_out !== prev_sw) begin
        if (q_sw.size() == 0) begin
          chk("sw_unexp", 32'(sw_out), 32'(prev_sw));
        end else begin
          ev = q_sw.pop_front();
          chk("sw_edge", edge_n, ev.e);
          chk("sw_val", 32'(sw_out), 32'(ev.v));
        end
        prev_sw = sw_out;
      end
      if (step_pulse) begin
        if (q_pl.size() == 0) begin
          chk("pulse_unexp", 32'(step_pulse), 0);
        end else begin
          ev = q_pl.pop_front();
          chk("pulse_edge", edge_n, ev.e);
          chk("pulse_cnt", 32'(step_count), 32'(ev.v));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input logic [1:0] v, input int defer);
    sw_raw = v;
    q_sw.push_back('{edge_n + D + 2 + defer, 8'(v)});
  endtask

  task automatic press(input int hold);
    btn_raw = 1'b1;
    m_cnt = m_cnt + 8'd1;
    q_pl.push_back('{edge_n + D + 2, m_cnt});
    tick(hold);
    btn_raw = 1'b0;
    tick(D + 6);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    q_sw.delete();
    q_pl.delete();
    m_cnt = 8'd0;
    tick(n);
    reset = 1'b1;
  endtask

  initial begin
    tick(3);
    chk("rst_sw", 32'(sw_out), 0);
    chk("rst_pulse", 32'(step_pulse), 0);
    chk("rst_cnt", 32'(step_count), 0);
    reset = 1'b1;
    tick(3);

    set_sw(2'b10, 0);
    tick(D + 1);
    chk("sw_lat_before", 32'(sw_out), 0);
    tick(1);
    chk("sw_lat_at", 32'(sw_out), 2);
    tick(4);

    sw_raw = 2'b11;
    tick(3);
    sw_raw = 2'b10;
    tick(D + 4);
    chk("glitch_sw", 32'(sw_out), 2);
    chk("glitch_cnt", 32'(dut.u_sw0.r_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b1;
      tick(1 + (i % 2));
      btn_raw = 1'b0;
      tick(1);
    end
    press(50);
    chk("one_press_cnt", 32'(step_count), 1);

    set_sw(2'b01, 1);
    press(20);
    chk("defer_cnt", 32'(step_count), 2);
    chk("defer_sw", 32'(sw_out), 1);

    set_sw(2'b00, 0);
    tick(2);
    press(10);
    chk("indep_cnt", 32'(step_count), 3);

    set_sw(2'b11, 0);
    tick(D + 4);
    btn_raw = 1'b1;
    sw_raw = 2'b00;
    tick(2);
    reset = 1'b0;
    btn_raw = 1'b0;
    q_sw.delete();
    q_pl.delete();
    m_cnt = 8'd0;
    tick(1);
    chk("rst2_sw", 32'(sw_out), 0);
    chk("rst2_pulse", 32'(step_pulse), 0);
    chk("rst2_cnt", 32'(step_count), 0);
    tick(2);
    reset = 1'b1;
    tick(D + 8);
    chk("rst2_nopulse", 32'(step_count), 0);

    btn_raw = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    m_cnt = m_cnt + 8'd1;
    q_pl.push_back('{edge_n + D + 2, m_cnt});
    tick(20);
    btn_raw = 1'b0;
    tick(D + 6);
    chk("held_rst_cnt", 32'(step_count), 1);

    do_reset(2);
    tick(2);
    for (int i = 0; i < 256; i++) press(D + 2);
    chk("wrap_cnt", 32'(step_count), 0);

`ifdef STEP_AUTOREPEAT_EN
    btn_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_cnt = m_cnt + 8'd1;
      q_pl.push_back('{edge_n + D + 2 + RP * k, m_cnt});
    end
    tick(25);
    btn_raw = 1'b0;
    tick(D + 8);
    chk("repeat_cnt", 32'(step_count), 3);
`endif

    tick(4);
    chk("sw_q_empty", q_sw.size(), 0);
    chk("pl_q_empty", q_pl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
